// File: rtl/cnn_pkg.sv
// Shared CNN-stage definitions: convolution FSM state encoding and accumulator sizing.
// Imported by every convolution-path module so the widths agree between stages.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_WIN = 3'd1,
        ST_MAC      = 3'd2,
        ST_FINISH   = 3'd3,
        ST_OUTPUT   = 3'd4,
        ST_RELEASE  = 3'd5
    } conv_state_t;

    // Full signed product width plus guard bits so n_terms products can never overflow.
    function automatic int acc_width(input int data_width, input int n_terms);
        return 2 * data_width + $clog2(n_terms) + 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with synchronous clear; product is registered before the add.
// Latency: a tap issued with en_i is in acc_o two edges later.
// Backpressure: none, issue is paced entirely by en_i.
module conv_mac
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = acc_width(32, 9)
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0]    prod_q, prod_d;
    logic                        prod_vld_q, prod_vld_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = en_i;
        acc_d      = acc_q;
        if (en_i) begin
            prod_d = PROD_W'(a_i) * PROD_W'(b_i);
        end
        // Clear also drops any product still in flight from a previous run.
        if (clr_i) begin
            acc_d      = '0;
            prod_vld_d = 1'b0;
        end else if (prod_vld_q) begin
            acc_d = acc_q + ACC_WIDTH'(prod_q);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/conv_unit.sv
// Convolves one captured window against the live kernel, adds bias, saturates and optionally ReLUs.
// Latency: result_valid_o rises N_CHANNELS*T_C+2 edges after the window transfer edge.
// Backpressure: result held until result_ready_i; no new window accepted while a result is pending.
module conv_unit
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int N_CHANNELS  = 1,
    parameter int KERNEL_SIZE = 3,
    parameter int N_WINDOWS   = 676,
    parameter int RELU        = 1
) (
    input  logic                                                              clock_i,
    input  logic                                                              reset_i,
    input  logic [N_CHANNELS-1:0][KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel_i,
    input  logic [N_CHANNELS-1:0]                                             kernel_valid_i,
    input  logic [DATA_WIDTH-1:0]                                             bias_i,
    output logic [N_CHANNELS-1:0]                                             hold_kernel_o,
    input  logic [N_CHANNELS-1:0][KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_i,
    input  logic                                                              window_valid_i,
    output logic                                                              window_ready_o,
    output logic [DATA_WIDTH-1:0]                                             result_o,
    output logic                                                              result_valid_o,
    input  logic                                                              result_ready_i
);

    localparam int T_C    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int N_TAPS = N_CHANNELS * T_C;
    localparam int ACC_W  = acc_width(DATA_WIDTH, N_TAPS);
    localparam int SUM_W  = ACC_W + 1;
    localparam int TAP_W  = $clog2(N_TAPS + 1);
    localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int WIN_W  = (N_WINDOWS > 1) ? $clog2(N_WINDOWS) : 1;

    localparam logic [TAP_W-1:0]        TAP_END  = TAP_W'(N_TAPS);
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(N_WINDOWS - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    conv_state_t                      state_q, state_d;
    logic [TAP_W-1:0]                 tap_q, tap_d;
    logic [WIN_W-1:0]                 win_cnt_q, win_cnt_d;
    logic [N_TAPS-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic [DATA_WIDTH-1:0]            result_q, result_d;
    logic [N_CHANNELS-1:0]            hold_q, hold_d;

    logic [N_TAPS-1:0][DATA_WIDTH-1:0] kern_flat;
    logic [IDX_W-1:0]                 tap_idx;
    logic                             mac_clr, mac_en;
    logic signed [ACC_W-1:0]          acc;
    logic signed [SUM_W-1:0]          bias_sh, sum, scaled;
    logic [DATA_WIDTH-1:0]            sat_val, out_val;

    // Channel-major flattening: element c*T_C+t is channel c, tap t.
    assign kern_flat = kernel_i;
    assign tap_idx   = (tap_q < TAP_END) ? tap_q[IDX_W-1:0] : '0;

    conv_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_W)
    ) u_mac (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .a_i     (kern_flat[tap_idx]),
        .b_i     (win_q[tap_idx]),
        .acc_o   (acc)
    );

    always_comb begin
        bias_sh = SUM_W'($signed(bias_i)) <<< FRAC_BITS;
        sum     = SUM_W'(acc) + bias_sh;
        scaled  = sum >>> FRAC_BITS;
        if (scaled > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (scaled < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_val = scaled[DATA_WIDTH-1:0];
        end
        out_val = ((RELU != 0) && sat_val[DATA_WIDTH-1]) ? '0 : sat_val;
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        win_cnt_d = win_cnt_q;
        win_d     = win_q;
        result_d  = result_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (&kernel_valid_i) begin
                    state_d = ST_WAIT_WIN;
                end
            end
            ST_WAIT_WIN: begin
                if (window_valid_i) begin
                    win_d   = window_i;
                    mac_clr = 1'b1;
                    tap_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                // One issue per tap, then one extra cycle to drain the product register.
                if (tap_q < TAP_END) begin
                    mac_en = 1'b1;
                    tap_d  = tap_q + TAP_W'(1);
                end else begin
                    tap_d   = '0;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                result_d = out_val;
                state_d  = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (result_ready_i) begin
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        state_d   = ST_RELEASE;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        state_d   = ST_WAIT_WIN;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        hold_d = {N_CHANNELS{state_d != ST_RELEASE}};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            win_cnt_q <= '0;
            win_q     <= '0;
            result_q  <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            win_cnt_q <= win_cnt_d;
            win_q     <= win_d;
            result_q  <= result_d;
            hold_q    <= hold_d;
        end
    end

    assign hold_kernel_o  = hold_q;
    assign window_ready_o = (state_q == ST_WAIT_WIN);
    assign result_valid_o = (state_q == ST_OUTPUT);
    assign result_o       = result_q;

endmodule

// File: tb/tb_conv_unit.sv
// Two conv_unit instances (RELU on / off, two windows per kernel) share one stimulus stream;
// each result is compared with constants or a wide-integer arithmetic model of the convolution.
module tb_conv_unit;

    logic                   clk;
    logic                   rst;
    logic [0:0][8:0][31:0]  kernel;
    logic [0:0]             kernel_valid;
    logic [31:0]            bias;
    logic [0:0][8:0][31:0]  window;
    logic                   window_valid;
    logic                   result_ready;

    logic [0:0]  hold_r, hold_l;
    logic        win_rdy_r, win_rdy_l, vld_r, vld_l;
    logic [31:0] res_r, res_l;

    int n_checks = 0;
    int n_pass   = 0;
    int nw       = 0;

    conv_unit #(.DATA_WIDTH(32), .FRAC_BITS(16), .N_CHANNELS(1), .KERNEL_SIZE(3),
                .N_WINDOWS(2), .RELU(1)) u_relu (
        .clock_i(clk), .reset_i(rst), .kernel_i(kernel), .kernel_valid_i(kernel_valid),
        .bias_i(bias), .hold_kernel_o(hold_r), .window_i(window), .window_valid_i(window_valid),
        .window_ready_o(win_rdy_r), .result_o(res_r), .result_valid_o(vld_r),
        .result_ready_i(result_ready));

    conv_unit #(.DATA_WIDTH(32), .FRAC_BITS(16), .N_CHANNELS(1), .KERNEL_SIZE(3),
                .N_WINDOWS(2), .RELU(0)) u_lin (
        .clock_i(clk), .reset_i(rst), .kernel_i(kernel), .kernel_valid_i(kernel_valid),
        .bias_i(bias), .hold_kernel_o(hold_l), .window_i(window), .window_valid_i(window_valid),
        .window_ready_o(win_rdy_l), .result_o(res_l), .result_valid_o(vld_l),
        .result_ready_i(result_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Exact real-number convolution in 128-bit integers, then floor, clamp and ReLU.
    function automatic logic [31:0] model(input logic [8:0][31:0] k, input logic [8:0][31:0] w,
                                          input logic [31:0] b, input bit relu);
        logic signed [127:0] s, p;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            p = $signed(k[i]) * $signed(w[i]);
            s = s + p;
        end
        p = $signed(b);
        s = (s + (p <<< 16)) >>> 16;
        if (s > 128'sd2147483647) s = 128'sd2147483647;
        if (s < -128'sd2147483648) s = -128'sd2147483648;
        if (relu && s < 0) s = 0;
        return s[31:0];
    endfunction

    task automatic do_window(input string tag, input logic [31:0] exp_r, input logic [31:0] exp_l,
                             input int stall);
        int waitc;
        int lat;
        waitc = 0;
        while (!(win_rdy_r && win_rdy_l) && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        check({tag, " window_ready"}, {31'd0, win_rdy_r & win_rdy_l}, 32'd1);
        window_valid = 1'b1;
        @(posedge clk); #1;
        // Window register must hold the transferred value, not the live input.
        window = ~window;
        lat = 0;
        while (!vld_r && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        window_valid = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'd11);
        check({tag, " valid lin"}, {31'd0, vld_l}, 32'd1);
        check({tag, " result relu"}, res_r, exp_r);
        check({tag, " result lin"}, res_l, exp_l);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, " stall flags"}, {29'd0, vld_r, vld_l, win_rdy_r | win_rdy_l}, 32'd6);
            check({tag, " stall result"}, res_l, exp_l);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check({tag, " single transfer"}, {30'd0, vld_r, vld_l}, 32'd0);
        nw++;
        if (nw == 2) begin
            nw = 0;
            check({tag, " release hold"}, {30'd0, hold_r, hold_l}, 32'd0);
            @(posedge clk); #1;
            check({tag, " idle hold"}, {29'd0, hold_r, hold_l, win_rdy_r}, 32'd6);
        end else begin
            check({tag, " next wait"}, {29'd0, hold_r, hold_l, win_rdy_r}, 32'd7);
        end
    endtask

    typedef struct {
        logic [31:0] k;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic [31:0] exp_l;
        int          stall;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] r;
    logic [31:0] er, el;
    int          pulses;

    initial begin
        vecs[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0012_8000, 32'h0012_8000, 5};
        vecs[1] = '{32'h0001_0000, 32'hFFFE_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFEE_0000, 0};
        vecs[2] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1};
        vecs[3] = '{32'h7FFF_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[4] = '{32'h0000_8000, 32'h0003_0000, 32'hFFFF_0000, 32'h000C_8000, 32'h000C_8000, 2};
        vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0};

        rst = 1'b1; kernel = '0; kernel_valid = 1'b0; bias = '0; window = '0;
        window_valid = 1'b0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {27'd0, hold_r, hold_l, win_rdy_r, vld_r, vld_l}, 32'd0);
        check("reset result", res_r | res_l, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle hold", {29'd0, hold_r, hold_l, win_rdy_r}, 32'd6);
        repeat (3) @(posedge clk);
        #1;
        check("idle waits kernel", {31'd0, win_rdy_r | win_rdy_l}, 32'd0);
        kernel_valid = 1'b1;

        for (int v = 0; v < 6; v++) begin
            kernel = {9{vecs[v].k}};
            window = {9{vecs[v].w}};
            bias   = vecs[v].b;
            do_window($sformatf("vec%0d", v), vecs[v].exp_r, vecs[v].exp_l, vecs[v].stall);
        end

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 9; i++) begin
                r = $urandom;
                kernel[0][i] = (n < 5) ? {{14{r[17]}}, r[17:0]} : r;
                r = $urandom;
                window[0][i] = (n < 5) ? {{14{r[17]}}, r[17:0]} : r;
            end
            r = $urandom;
            bias = {{12{r[19]}}, r[19:0]};
            er = model(kernel[0], window[0], bias, 1'b1);
            el = model(kernel[0], window[0], bias, 1'b0);
            do_window($sformatf("rnd%0d", n), er, el, n % 3);
        end

        // Abort mid-MAC: reset lands on the edge ending the 4th MAC cycle.
        kernel = {9{vecs[0].k}};
        window = {9{vecs[0].w}};
        bias   = vecs[0].b;
        pulses = 0;
        while (!win_rdy_r && pulses < 20) begin
            @(posedge clk); #1; pulses++;
        end
        window_valid = 1'b1;
        @(posedge clk); #1;
        window_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort flags", {27'd0, hold_r, hold_l, win_rdy_r, vld_r, vld_l}, 32'd0);
        check("abort result", res_r | res_l, 32'd0);
        check("abort acc", {31'd0, |u_relu.u_mac.acc_o}, 32'd0);
        rst = 1'b0;
        nw = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (vld_r || vld_l) pulses++;
        end
        check("abort no pulse", 32'(pulses), 32'd0);
        do_window("fresh", vecs[0].exp_r, vecs[0].exp_l, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_unit.md
CONV_UNIT -- requirements
Module: conv_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32: width of kernel, bias, window and result words (signed fixed point).
REQ-002 Parameter FRAC_BITS, 16: fractional bits of every DATA_WIDTH word.
REQ-003 Parameter N_CHANNELS, 1: input channels accumulated into one result.
REQ-004 Parameter KERNEL_SIZE, 3: kernel edge; taps per channel T_C = KERNEL_SIZE*KERNEL_SIZE.
REQ-005 Parameter N_WINDOWS, 676: windows convolved per loaded kernel before release.
REQ-006 Parameter RELU, 1: 1 applies ReLU to the result; 0 bypasses it.
REQ-007 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-008 clock_i  in  1  sole clock; all state changes on its rising edge.
REQ-009 reset_i  in  1  synchronous, active-high reset.
REQ-010 kernel_i  in  [N_CHANNELS][T_C] x DATA_WIDTH  kernel taps from the kernel buffer.
REQ-011 kernel_valid_i  in  [N_CHANNELS] x 1  per-channel kernel valid.
REQ-012 bias_i  in  DATA_WIDTH  bias of the current kernel.
REQ-013 hold_kernel_o  out  [N_CHANNELS] x 1  1 = keep kernel; 0 for one cycle = release it.
REQ-014 window_i  in  [N_CHANNELS][T_C] x DATA_WIDTH  input pixel window.
REQ-015 window_valid_i / window_ready_o  in/out  1  window handshake; transfer when both are 1 at an edge.
REQ-016 result_o  out  DATA_WIDTH  convolved, biased, saturated (and ReLU'd) output pixel.
REQ-017 result_valid_o / result_ready_i  out/in  1  result handshake; transfer when both are 1.

Function
REQ-018 FSM states: IDLE, WAIT_WIN, MAC, FINISH, OUTPUT, RELEASE.
REQ-019 IDLE: hold_kernel_o all 1; go to WAIT_WIN when every kernel_valid_i[c] is 1 at the same edge.
REQ-020 WAIT_WIN: window_ready_o=1; on transfer, capture window_i into an internal register, clear the accumulator, go to MAC.
REQ-021 MAC: one signed tap product per cycle, channel-major then tap index 0..T_C-1, for N_CHANNELS*T_C cycles; then go to FINISH.
REQ-022 Product width 2*DATA_WIDTH; accumulator width 2*DATA_WIDTH+clog2(N_CHANNELS*T_C)+1; no intermediate overflow.
REQ-023 FINISH (1 cycle): add bias_i sign-extended and shifted left by FRAC_BITS; arithmetic shift right by FRAC_BITS; saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if RELU=1, clamp negatives to 0; register into result_o; go to OUTPUT.
REQ-024 Latency: result_valid_o SHALL rise exactly N_CHANNELS*T_C+2 edges after the window transfer edge.
REQ-025 OUTPUT: result_valid_o=1 and result_o stable until a result transfer; window_ready_o=0 throughout.
REQ-026 On result transfer, increment the window counter; if it reaches N_WINDOWS, clear it and go to RELEASE, otherwise go to WAIT_WIN.
REQ-027 RELEASE (1 cycle): hold_kernel_o all 0; then IDLE. hold_kernel_o is 1 in every other non-reset state.
REQ-028 kernel_i and bias_i SHALL be read directly (not copied); kernel_valid_i dropping while hold_kernel_o=1 is a protocol violation, and the block continues unchanged.
REQ-029 window_valid_i outside WAIT_WIN is ignored; at most one window is in flight.

Reset
REQ-030 reset_i SHALL take priority over all other inputs and abort any operation mid-flight; no partial result is emitted.
REQ-031 Reset values: state IDLE, hold_kernel_o 0, window_ready_o 0, result_valid_o 0, result_o 0, accumulator 0, tap and window counters 0.

Structure
REQ-032 Package cnn_pkg SHALL hold the FSM state enum and the accumulator-width function/constant shared with other CNN stages.
REQ-033 The signed multiply-accumulate with clear SHALL be the sub-module conv_mac; saturation and ReLU stay in conv_unit.

Verification (KERNEL_SIZE=3, N_CHANNELS=1, FRAC_BITS=16, DATA_WIDTH=32)
REQ-034 Kernel all 0x00010000, window all 0x00020000, bias 0x00008000 -> result_o=0x00128000 (18.5); result_valid_o rises 11 edges after the window transfer.
REQ-035 Kernel all 0x00010000, window all 0xFFFE0000, bias 0, RELU=1 -> result_o=0; with RELU=0 -> 0xFFEE0000 (-18.0).
REQ-036 Kernel and window all 0x7FFF0000 -> result_o=0x7FFFFFFF (positive saturation).
REQ-037 result_ready_i held at 0 for 5 cycles -> result_valid_o and result_o held stable, window_ready_o=0; single transfer on the first ready cycle.
REQ-038 N_WINDOWS=2: after the second result transfer, hold_kernel_o=0 for exactly one cycle, then 1; a new kernel_valid_i starts the next cycle of windows.
REQ-039 reset_i asserted at the 4th MAC cycle -> next edge shows all REQ-031 values, no result_valid_o pulse; a fresh run afterward matches REQ-034.
